jk_excitation_driver: RTL and testbench

//  Drive side of the JK flip-flop interface: turns a requested Q bit sequence into per-cycle J/K

---
 rtl/jk_excitation_driver_if.sv | 30 +++
 rtl/jk_excitation_driver.sv | 154 +++++++++++++++
 tb/tb_jk_excitation_driver.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_excitation_driver_if.sv
// jk_excitation_driver_if: request, flop feedback and status bundle.
// master = pattern source / test controller, slave = jk_excitation_driver.
//   start, pattern, q_fb  : master -> slave
//   j, k                  : registered JK commands to the driven flop
//   busy, done            : run status (done is a one-cycle pulse)
//   mismatch, err_count   : sticky fault flag and saturating fault count
interface jk_excitation_driver_if #(
    parameter int W     = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [W-1:0]     pattern;
    logic             q_fb;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [CNT_W-1:0] err_count;

    modport master (
        output start, pattern, q_fb,
        input  j, k, busy, done, mismatch, err_count
    );

    modport slave (
        input  start, pattern, q_fb,
        output j, k, busy, done, mismatch, err_count
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: turns a requested Q bit sequence (LSB first) into
// registered J/K commands and checks the flop's fed-back Q against it.
// Ports: clk, reset (sync, active-high), bus (jk_excitation_driver_if.slave).
// Macro JK_TOGGLE_PREF_EN: resolve transition don't-cares to toggle (1,1).
module jk_excitation_driver #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    jk_excitation_driver_if.slave  bus
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DRIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     pat_q, pat_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             qm_q, qm_d;
    logic             v0_q, v0_d, b0_q, b0_d;
    logic             v1_q, v1_d, b1_q, b1_d;
    logic             j_q, j_d, k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic tgt;
    logic exc_j;
    logic exc_k;

    assign tgt = pat_q[idx_q];

`ifdef JK_TOGGLE_PREF_EN
    assign exc_j = qm_q ^ tgt;
    assign exc_k = qm_q ^ tgt;
`else
    assign exc_j = ~qm_q & tgt;
    assign exc_k = qm_q & ~tgt;
`endif

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        qm_d    = qm_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        // Stage 0 holds the bit just driven; stage 1 the bit the flop
        // has just taken, so q_fb is compared against stage 1.
        v0_d    = 1'b0;
        b0_d    = 1'b0;
        v1_d    = v0_q;
        b1_d    = b0_q;

        if (v1_q && (bus.q_fb != b1_q)) begin
            mis_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    pat_d   = bus.pattern;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    mis_d   = 1'b0;
                    cnt_d   = '0;
                    k_d     = 1'b1;
                    qm_d    = 1'b0;
                end
            end
            S_CLEAR, S_DRIVE: begin
                j_d     = exc_j;
                k_d     = exc_k;
                qm_d    = tgt;
                v0_d    = 1'b1;
                b0_d    = tgt;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == LAST) ? S_DRAIN : S_DRIVE;
            end
            S_DRAIN: begin
                // Stage 0 empty means this edge performs the final check.
                if (!v0_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            qm_q    <= 1'b0;
            v0_q    <= 1'b0;
            b0_q    <= 1'b0;
            v1_q    <= 1'b0;
            b1_q    <= 1'b0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            qm_q    <= qm_d;
            v0_q    <= v0_d;
            b0_q    <= b0_d;
            v1_q    <= v1_d;
            b1_q    <= b1_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mismatch  = mis_q;
    assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver: directed and randomized runs of jk_excitation_driver
// against a run-timeline model; a second instance uses CNT_W=2 with q_fb tied 0.
module tb_jk_excitation_driver;
    localparam int W      = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_W2 = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jk_excitation_driver_if #(.W(W), .CNT_W(CNT_W))  bus ();
    jk_excitation_driver_if #(.W(W), .CNT_W(CNT_W2)) bus2 ();

    jk_excitation_driver #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    jk_excitation_driver #(.W(W), .CNT_W(CNT_W2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    // q_fb source: 0 = ideal JK flop, 1 = stuck at 0, 2 = random
    int   mode = 0;
    logic plant_q = 1'b0;
    logic rnd_q = 1'b0;
    logic start = 1'b0;
    logic [W-1:0] pattern = '0;

    assign bus.start    = start;
    assign bus.pattern  = pattern;
    assign bus.q_fb     = (mode == 0) ? plant_q : (mode == 1) ? 1'b0 : rnd_q;
    assign bus2.start   = start;
    assign bus2.pattern = pattern;
    assign bus2.q_fb    = 1'b0;

    always @(posedge clk) begin
        if (bus.j && bus.k)      plant_q <= ~plant_q;
        else if (bus.j)          plant_q <= 1'b1;
        else if (bus.k)          plant_q <= 1'b0;
    end

    always @(negedge clk) rnd_q <= 1'($urandom);

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Excitation table as a lookup: {q,next} -> {j,k}
    function automatic logic [1:0] exc(input logic q, input logic t);
        logic [1:0] tbl [4];
`ifdef JK_TOGGLE_PREF_EN
        tbl = '{2'b00, 2'b11, 2'b11, 2'b00};
`else
        tbl = '{2'b00, 2'b10, 2'b01, 2'b00};
`endif
        return tbl[{q, t}];
    endfunction

    // Run timeline model: m_n counts edges since the accepting edge.
    bit           m_live = 0;
    bit           m_act = 0;
    int           m_n = 0;
    logic [W-1:0] m_pat = '0;
    bit           m_mis = 0;
    bit           m_mis2 = 0;
    int           m_cnt = 0;
    int           m_cnt2 = 0;

    always @(posedge clk) begin
        m_live = 1;
        if (reset) begin
            m_act = 0; m_n = 0;
            m_mis = 0; m_mis2 = 0; m_cnt = 0; m_cnt2 = 0;
        end else if (m_act) begin
            m_n++;
            if (m_n >= 3 && m_n <= W + 2) begin
                if (bus.q_fb !== m_pat[m_n-3]) begin
                    m_mis = 1;
                    if (m_cnt < 2**CNT_W - 1) m_cnt++;
                end
                if (m_pat[m_n-3]) begin
                    m_mis2 = 1;
                    if (m_cnt2 < 2**CNT_W2 - 1) m_cnt2++;
                end
            end
            if (m_n == W + 3) m_act = 0;
        end else if (bus.start) begin
            m_act = 1; m_n = 0; m_pat = bus.pattern;
            m_mis = 0; m_mis2 = 0; m_cnt = 0; m_cnt2 = 0;
        end
    end

    function automatic logic [1:0] exp_jk();
        logic prev;
        if (!m_act) return 2'b00;
        if (m_n == 0) return 2'b01;
        if (m_n <= W) begin
            prev = (m_n == 1) ? 1'b0 : m_pat[m_n-2];
            return exc(prev, m_pat[m_n-1]);
        end
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        if (m_live) begin
            chk("jk",        {bus.j, bus.k},  exp_jk());
            chk("busy",      bus.busy,        m_act && m_n <= W + 1);
            chk("done",      bus.done,        m_act && m_n == W + 2);
            chk("mismatch",  bus.mismatch,    m_mis);
            chk("err_count", bus.err_count,   m_cnt);
            chk("jk2",       {bus2.j, bus2.k}, exp_jk());
            chk("done2",     bus2.done,       m_act && m_n == W + 2);
            chk("mismatch2", bus2.mismatch,   m_mis2);
            chk("err_count2", bus2.err_count, m_cnt2);
        end
    end

    task automatic wait_done(input int from_n, output int at_n);
        at_n = from_n;
        while (!bus.done && at_n < from_n + 40) begin
            @(negedge clk);
            at_n++;
        end
        if (!bus.done) begin
            n_checks++; n_errors++;
            $display("FAIL done_timeout: got 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((bus.busy || bus.done) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy || bus.done) begin
            n_checks++; n_errors++;
            $display("FAIL idle_timeout: got busy expected idle at %0t", $time);
        end
    endtask

    task automatic launch(input logic [W-1:0] p);
        pattern = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] lit [8];
        int at;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_jk",   {bus.j, bus.k}, 2'b00);
        chk("rst_busy", bus.busy,       1'b0);
        chk("rst_done", bus.done,       1'b0);
        chk("rst_mis",  bus.mismatch,   1'b0);
        chk("rst_err",  bus.err_count,  0);
        reset = 1'b0;
        @(negedge clk);

        // pattern 1011_0010, ideal flop
`ifdef JK_TOGGLE_PREF_EN
        lit = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
`else
        lit = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
`endif
        mode = 0;
        launch(8'b1011_0010);
        chk("clear_jk", {bus.j, bus.k}, 2'b01);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("seq_jk%0d", i), {bus.j, bus.k}, lit[i]);
        end
        wait_done(8, at);
        chk("done_edge", at + 1, 11);
        chk("t2_mis", bus.mismatch,  1'b0);
        chk("t2_err", bus.err_count, 0);
        @(negedge clk);
        chk("t2_done_1cyc", bus.done, 1'b0);

        // all ones with q_fb stuck at 0; second instance saturates
        mode = 1;
        launch(8'hFF);
        wait_done(0, at);
        chk("t3_mis",  bus.mismatch,   1'b1);
        chk("t3_err",  bus.err_count,  8);
        chk("t3_err2", bus2.err_count, 3);
        wait_idle();
        chk("t3_hold_err", bus.err_count, 8);
        @(negedge clk);

        // start re-asserted at E3 is ignored
        mode = 0;
        launch(8'h3C);
        @(negedge clk);
        @(negedge clk);
        pattern = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, at);
        chk("t4_done_edge", at + 1, 11);
        chk("t4_err", bus.err_count, 0);
        wait_idle();

        // reset at E4 of a run
        launch(8'h96);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_jk",   {bus.j, bus.k}, 2'b00);
        chk("t5_busy", bus.busy,       1'b0);
        chk("t5_done", bus.done,       1'b0);
        launch(8'h5A);
        wait_done(0, at);
        chk("t5_err", bus.err_count, 0);
        wait_idle();

`ifdef JK_TOGGLE_PREF_EN
        lit = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        launch(8'b0000_0101);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("tog_jk%0d", i), {bus.j, bus.k}, lit[i]);
        end
        wait_done(8, at);
        chk("tog_mis", bus.mismatch, 1'b0);
        wait_idle();
`endif

        // randomized runs, random feedback, occasional mid-run reset
        for (int r = 0; r < 60; r++) begin
            mode = $urandom_range(0, 2);
            pattern = W'($urandom);
            start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                wait_idle();
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // start held high: back-to-back runs
        mode = 0;
        start = 1'b1;
        for (int c = 0; c < 35; c++) begin
            pattern = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
